fft_job_scheduler: RTL
======================

Name: fft_job_scheduler

Overview:
- Shares one 256-point FFT engine between NUM_REQ requesters using round-robin order.
- Per job: grants one requester, pulses the engine start, forwards exactly FFT_SIZE input samples with generated addresses, then tags the engine's result stream with the owner ID until the engine signals done.
- Sits between the sample sources/sinks and the FFT engine; it is the engine's only driver.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 16, sample component width.
- FFT_SIZE, 256, points per job.
- ADDR_WIDTH, 8, log2(FFT_SIZE).
- TIMEOUT_CYCLES, 8192, maximum cycles in WAIT before abort.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req  in  NUM_REQ  per-requester job request (level).
- grant  out  NUM_REQ  one-hot owner of the current job.
- in_real / in_imag  in  DATA_WIDTH each  shared input sample bus, driven by the granted requester.
- in_valid  in  1  input sample valid.
- in_ready  out  1  scheduler accepts the sample this cycle.
- eng_start  out  1  one-cycle engine start pulse.
- eng_in_real / eng_in_imag  out  DATA_WIDTH each  sample to engine.
- eng_in_addr  out  ADDR_WIDTH  sample index.
- eng_in_valid  out  1  sample valid to engine.
- eng_busy  in  1  engine busy.
- eng_done  in  1  engine done pulse.
- eng_out_real / eng_out_imag  in  DATA_WIDTH each  engine result.
- eng_out_addr  in  ADDR_WIDTH  result bin index.
- eng_out_valid  in  1  engine result valid.
- out_real / out_imag  out  DATA_WIDTH each  registered result.
- out_addr  out  ADDR_WIDTH  registered result bin index.
- out_valid  out  1  registered result valid.
- out_id  out  $clog2(NUM_REQ)  owner of the result stream.
- job_done  out  1  one-cycle pulse at end of job.
- err_timeout  out  1  sticky timeout flag.
- job_count  out  16  completed-job counter (optional feature).

Behaviour:
- Reset: state IDLE; rr pointer 0; all outputs 0.
- IDLE:
  - If no req bit is set, stay in IDLE.
  - Otherwise pick the first set req bit at or after the pointer (wrapping); latch owner, set grant, go START.
- START:
  - eng_start=1 for exactly one cycle; load counter cleared; go LOAD next cycle.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready: eng_in_* are registered copies of in_* (1-cycle latency); eng_in_addr=load counter; counter increments.
  - Accepting sample FFT_SIZE-1 moves to WAIT; in_ready drops the same cycle the last sample is accepted.
  - Gaps in in_valid are allowed and the counter holds.
- WAIT:
  - eng_out_* are registered into out_* with 1-cycle latency; out_id=owner.
  - On eng_done: job_done=1 for one cycle, grant cleared, pointer=owner+1 mod NUM_REQ, go IDLE.
  - The wait counter clears on entering WAIT.
  - If the wait counter reaches TIMEOUT_CYCLES-1: set err_timeout, clear grant, advance pointer, go IDLE; job_done stays low.
- Grant lifetime: grant is held from IDLE exit through job end. Deassertion of the owner's req mid-job is ignored; the job still runs to completion.
- Arbitration timing: arbitration is evaluated only in IDLE; new req edges during a job wait.
- Fairness: back-to-back jobs alternate among all active requesters.
- eng_done outside WAIT is ignored. eng_out_valid outside WAIT is dropped (out_valid stays 0).
- err_timeout clears only on the next START or on rst.
- rst mid-job: immediate return to reset values. No eng_start is reissued.
- Counters: the load counter is ADDR_WIDTH+1 bits and compares against FFT_SIZE-1. The wait counter is $clog2(TIMEOUT_CYCLES)+1 bits.

Optional Feature:
- FFT_SCHED_STATS_EN defined: job_count increments on each job_done, saturating at 16'hFFFF, and is cleared by rst. Timeouts are not counted.
- Not defined: job_count is tied to 0 and no counter register is synthesised.

Decomposition:
- Package fft_sched_pkg holds:
  - the state enum sched_state_t {IDLE, START, LOAD, WAIT};
  - localparam defaults for FFT_SIZE, ADDR_WIDTH, DATA_WIDTH;
  - an id-width helper function.
- Sub-module fft_rr_arbiter (combinational pick + pointer register, NUM_REQ parameter) returns a one-hot grant and an encoded index. The scheduler instantiates it once.

Test Plan:
- Single job: req=4'b0001, 256 back-to-back samples.
  - grant=0001; eng_start pulses 1 cycle after grant.
  - eng_in_addr runs 0..255.
  - Model eng_done 300 cycles later: job_done pulse, out_id=0 on all tagged outputs.
- Round-robin: req=4'b1011 held for 3 jobs -> grant order 0001, 0010, 1000; pointer wraps to 0 on the 4th job.
- Throttled input: in_valid toggles every other cycle -> exactly 256 eng_in_valid pulses; addresses contiguous; WAIT entered after the 256th accept only.
- Timeout: TIMEOUT_CYCLES=64, eng_done never asserted -> err_timeout=1 at WAIT cycle 64, grant cleared, job_done=0; next job's START clears the flag.
- Reset mid-LOAD at sample 100: all outputs 0 the cycle after rst, state IDLE. A subsequent job starts at eng_in_addr 0.
- With FFT_SCHED_STATS_EN defined, 3 completed jobs plus 1 timeout -> job_count=3.

Source files
------------

// File: rtl/fft_sched_pkg.sv
// rtl/fft_sched_pkg.sv - shared types, defaults and helpers for the FFT job scheduler
package fft_sched_pkg;

  typedef enum logic [1:0] {IDLE, START, LOAD, WAIT} sched_state_t;

  localparam int FFT_SIZE_DEF   = 256;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 16;

  // Width of an encoded requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fft_rr_arbiter.sv
// rtl/fft_rr_arbiter.sv - round-robin pick with a pointer register that advances past the finished owner
module fft_rr_arbiter
  import fft_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDW = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv,
  input  logic [IDW-1:0]     adv_id,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_id,
  output logic               gnt_any
);

  logic [IDW-1:0] ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (adv_id == IDW'(NUM_REQ - 1)) ? '0 : adv_id + IDW'(1);
    end
  end

  // First pass covers ptr..top, second pass wraps around to the bottom.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!gnt_any && req[j] && (j >= int'(ptr))) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!gnt_any && req[j]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(j);
      end
    end
    gnt = gnt_any ? (NUM_REQ'(1) << gnt_id) : '0;
  end

endmodule

// File: rtl/fft_job_scheduler.sv
// rtl/fft_job_scheduler.sv - shares one FFT engine among NUM_REQ requesters, one job at a time
// Defining FFT_SCHED_STATS_EN adds the saturating completed-job counter on job_count.
module fft_job_scheduler
  import fft_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int FFT_SIZE       = FFT_SIZE_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 8192,
  localparam int IDW = id_width(NUM_REQ),
  localparam int LCW = ADDR_WIDTH + 1,
  localparam int WCW = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    grant,
  input  logic [DATA_WIDTH-1:0] in_real,
  input  logic [DATA_WIDTH-1:0] in_imag,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  eng_start,
  output logic [DATA_WIDTH-1:0] eng_in_real,
  output logic [DATA_WIDTH-1:0] eng_in_imag,
  output logic [ADDR_WIDTH-1:0] eng_in_addr,
  output logic                  eng_in_valid,
  input  logic                  eng_busy,
  input  logic                  eng_done,
  input  logic [DATA_WIDTH-1:0] eng_out_real,
  input  logic [DATA_WIDTH-1:0] eng_out_imag,
  input  logic [ADDR_WIDTH-1:0] eng_out_addr,
  input  logic                  eng_out_valid,
  output logic [DATA_WIDTH-1:0] out_real,
  output logic [DATA_WIDTH-1:0] out_imag,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_valid,
  output logic [IDW-1:0]        out_id,
  output logic                  job_done,
  output logic                  err_timeout,
  output logic [15:0]           job_count
);

  sched_state_t       state, state_nxt;
  logic [IDW-1:0]     owner;
  logic [LCW-1:0]     load_cnt;
  logic [WCW-1:0]     wait_cnt;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDW-1:0]     arb_id;
  logic               arb_any, arb_adv, launch, accept, expired;

  fft_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .adv    (arb_adv),
    .adv_id (owner),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .gnt_any(arb_any)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // An engine still busy from an aborted job is never handed a new start.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    arb_adv   = 1'b0;
    launch    = 1'b0;
    accept    = 1'b0;
    expired   = (wait_cnt == WCW'(TIMEOUT_CYCLES - 1));
    case (state)
      IDLE: begin
        launch = arb_any && !eng_busy;
        if (launch) state_nxt = START;
      end
      START: state_nxt = LOAD;
      LOAD: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept && load_cnt == LCW'(FFT_SIZE - 1)) state_nxt = WAIT;
      end
      WAIT: begin
        if (eng_done || expired) begin
          state_nxt = IDLE;
          arb_adv   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant        <= '0;
      owner        <= '0;
      eng_start    <= 1'b0;
      eng_in_real  <= '0;
      eng_in_imag  <= '0;
      eng_in_addr  <= '0;
      eng_in_valid <= 1'b0;
      out_real     <= '0;
      out_imag     <= '0;
      out_addr     <= '0;
      out_valid    <= 1'b0;
      out_id       <= '0;
      job_done     <= 1'b0;
      err_timeout  <= 1'b0;
      load_cnt     <= '0;
      wait_cnt     <= '0;
    end else begin
      eng_start    <= 1'b0;
      eng_in_valid <= 1'b0;
      out_valid    <= 1'b0;
      job_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            grant <= arb_gnt;
            owner <= arb_id;
          end
        end
        START: begin
          eng_start   <= 1'b1;
          load_cnt    <= '0;
          err_timeout <= 1'b0;
        end
        LOAD: begin
          wait_cnt <= '0;
          if (accept) begin
            eng_in_real  <= in_real;
            eng_in_imag  <= in_imag;
            eng_in_addr  <= load_cnt[ADDR_WIDTH-1:0];
            eng_in_valid <= 1'b1;
            load_cnt     <= load_cnt + LCW'(1);
          end
        end
        WAIT: begin
          out_real  <= eng_out_real;
          out_imag  <= eng_out_imag;
          out_addr  <= eng_out_addr;
          out_valid <= eng_out_valid;
          out_id    <= owner;
          if (eng_done) begin
            job_done <= 1'b1;
            grant    <= '0;
          end else if (expired) begin
            err_timeout <= 1'b1;
            grant       <= '0;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FFT_SCHED_STATS_EN
  logic [15:0] job_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) job_cnt_q <= '0;
    else if (state == WAIT && eng_done && job_cnt_q != 16'hFFFF) job_cnt_q <= job_cnt_q + 16'd1;
  end
  assign job_count = job_cnt_q;
`else
  assign job_count = '0;
`endif

endmodule
